segment_to_character: RTL

//  Inverse of the character-to-segment encoder: samples a multiplexed, active-low 7-segment bus
//  (seg_in + active-low anodes) and rebuilds the 4-bit character code of each digit.

---
 rtl/segment_to_character.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/segment_to_character.sv
// Loopback decoder for a multiplexed, active-low 7-segment bus.
// Synchronizes {an_in, seg_in}, waits for a stable pattern, then rebuilds the
// 4-bit character code of the selected digit and tracks frame completion.
// Optional feature: define SEG_ERR_COUNT_EN to add err_count/err_clr.
module segment_to_character #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SEG_ERR_COUNT_EN
  input  logic                    err_clr,
  output logic [7:0]              err_count,
`endif
  output logic [4*NUM_DIGITS-1:0] char_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    code_err,
  output logic                    frame_done
);

  localparam int unsigned SW = NUM_DIGITS + 7;

  typedef enum logic {StWait, StHold} state_e;

  logic [SW-1:0]           sync1_q, sync2_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic                    same, commit, one_hot, match;
  logic [3:0]              code;
  logic [NUM_DIGITS-1:0]   an_low, sel;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, valid_q, valid_d;
  logic [4*NUM_DIGITS-1:0] char_q, char_d;
  logic                    code_err_q, code_err_d, frame_done_q, frame_done_d;

  // sync1_q is the sample about to enter sync2_q; equality means "same again"
  assign same    = (sync1_q == sync2_q);
  assign commit  = (state_q == StWait) && same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign an_low  = ~sync2_q[SW-1:7];
  assign one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
  assign sel     = one_hot ? an_low : '0;

  // Decode the synchronized segment pattern; unknown patterns yield 4'hF
  always_comb begin
    match = 1'b1;
    code  = 4'hF;
    unique case (sync2_q[6:0])
      7'b0000001: code = 4'd0;
      7'b0011000: code = 4'd1;
      7'b0110000: code = 4'd2;
      7'b1101010: code = 4'd3;
      7'b0110001: code = 4'd4;
      7'b1110001: code = 4'd5;
      7'b0100100: code = 4'd6;
      7'b1000010: code = 4'd7;
      7'b1100011: code = 4'd8;
      7'b1111010: code = 4'd9;
      7'b1111110: code = 4'd10;
      7'b1111111: code = 4'd11;
      default:    match = 1'b0;
    endcase
  end

  // Stability counter: count identical samples, saturate, restart on change
  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FSM next state: one commit per stable run
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWait:  if (commit) state_d = StHold;
      StHold:  if (!same)  state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  // Slot, valid, frame and pulse updates on a single-digit commit
  always_comb begin
    char_d       = char_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    code_err_d   = 1'b0;
    frame_done_d = 1'b0;
    if (commit && one_hot) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (sel[i]) begin
          char_d[4*i +: 4] = code;
          valid_d[i]       = match;
        end
      end
      code_err_d = !match;
      if ((seen_q | sel) == '1) begin
        seen_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        seen_d = seen_q | sel;
      end
    end
  end

  // State registers; reset leaves the synchronizer showing a dark display
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      cnt_q        <= '0;
      state_q      <= StWait;
      char_q       <= {NUM_DIGITS{4'hB}};
      valid_q      <= '0;
      seen_q       <= '0;
      code_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= {an_in, seg_in};
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      char_q       <= char_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      code_err_q   <= code_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign char_out    = char_q;
  assign digit_valid = valid_q;
  assign code_err    = code_err_q;
  assign frame_done  = frame_done_q;

`ifdef SEG_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Saturating error counter; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count_q <= '0;
    end else if (code_err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
